// File: rtl/pipe_pkg.sv
// Shared pipeline encodings and the ID/EX control bundle.
// Imported by the decode stage and its register file.
package pipe_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Widest ALU op field the bundle can carry.
  localparam int ALUC_MAXW = 8;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
    logic                 branch;
    logic                 jump;
    logic                 alusrc;
    logic [ALUC_MAXW-1:0] alucontrol;
  } idex_ctrl_t;

endpackage

// File: rtl/regfile_p.sv
// Architectural register file: 2 async reads, 1 sync write.
// x0 is hardwired to zero; optional write-first bypass.
module regfile_p
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1,
  localparam int AW       = rf_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [AW-1:0]   i_ra1,
  input  logic [AW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr;
  logic            w_hit1;
  logic            w_hit2;

  assign w_wr   = i_we && (i_wa != '0);
  assign w_hit1 = (WB_BYPASS != 0) && w_wr && (i_wa == i_ra1);
  assign w_hit2 = (WB_BYPASS != 0) && w_wr && (i_wa == i_ra2);

  // Clear on reset, otherwise write-back (never to x0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Port 1 read: x0 reads zero, bypass wins over array.
  always_comb begin
    o_rd1 = '0;
    if (i_ra1 != '0) begin
      o_rd1 = w_hit1 ? i_wd : r_mem[i_ra1];
    end
  end

  // Port 2 read: same rules as port 1.
  always_comb begin
    o_rd2 = '0;
    if (i_ra2 != '0) begin
      o_rd2 = w_hit2 ? i_wd : r_mem[i_ra2];
    end
  end

endmodule

// File: rtl/id_ex_stage_p.sv
// Decode stage: regfile read, immediate gen, load-use
// detection and the ID/EX pipeline register.
module id_ex_stage_p
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ALUC_W    = 3,
  parameter int WB_BYPASS = 1,
  localparam int AW       = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic              regwrite_d,
  input  logic [1:0]        resultsrc_d,
  input  logic              memwrite_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic              alusrc_d,
  input  logic [ALUC_W-1:0] alucontrol_d,
  input  logic [2:0]        immsrc_d,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              regwrite_w,
  input  logic [AW-1:0]     rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_req_o,
  output logic              valid_e,
  output logic              regwrite_e,
  output logic              memwrite_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic              alusrc_e,
  output logic [1:0]        resultsrc_e,
  output logic [ALUC_W-1:0] alucontrol_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   immext_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [AW-1:0]     rs1_e,
  output logic [AW-1:0]     rs2_e,
  output logic [AW-1:0]     rd_e
);

  idex_ctrl_t      r_ctrl;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [AW-1:0]   r_rd;

  idex_ctrl_t      w_ctrl_d;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_immext;
  logic            w_stall_req;
  logic            w_bubble;
  logic            w_unused;

  assign w_rs1 = instr_d[15 +: AW];
  assign w_rs2 = instr_d[20 +: AW];
  assign w_rd  = instr_d[7 +: AW];

  regfile_p #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .WB_BYPASS (WB_BYPASS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (regwrite_w),
    .i_wa  (rd_w),
    .i_wd  (result_w),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Immediate formats, 32-bit sign-extended before widening.
  always_comb begin
    w_imm32 = '0;
    case (immsrc_d)
      IMM_I: w_imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
      IMM_S: w_imm32 = {{20{instr_d[31]}}, instr_d[31:25],
                        instr_d[11:7]};
      IMM_B: w_imm32 = {{19{instr_d[31]}}, instr_d[31],
                        instr_d[7], instr_d[30:25],
                        instr_d[11:8], 1'b0};
      IMM_J: w_imm32 = {{11{instr_d[31]}}, instr_d[31],
                        instr_d[19:12], instr_d[20],
                        instr_d[30:21], 1'b0};
      IMM_U: w_imm32 = {instr_d[31:12], 12'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_immext = XLEN'($signed(w_imm32));

  // Decode controls; an invalid slot carries no controls.
  always_comb begin
    w_ctrl_d       = '0;
    w_ctrl_d.valid = valid_d;
    if (valid_d) begin
      w_ctrl_d.regwrite   = regwrite_d;
      w_ctrl_d.resultsrc  = resultsrc_d;
      w_ctrl_d.memwrite   = memwrite_d;
      w_ctrl_d.branch     = branch_d;
      w_ctrl_d.jump       = jump_d;
      w_ctrl_d.alusrc     = alusrc_d;
      w_ctrl_d.alucontrol = ALUC_MAXW'(alucontrol_d);
    end
  end

  assign w_stall_req = r_ctrl.valid
                    && (r_ctrl.resultsrc == RES_LOAD)
                    && (r_rd != '0)
                    && valid_d
                    && ((r_rd == w_rs1) || (r_rd == w_rs2));

  // Hold beats a load-use bubble; flush beats both.
  assign w_bubble = flush_i || (!stall_i && w_stall_req);

  // ID/EX register: reset, bubble, hold or capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_pc   <= '0;
      r_pc4  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else if (w_bubble) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_pc   <= '0;
      r_pc4  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else if (!stall_i) begin
      r_ctrl <= w_ctrl_d;
      r_rd1  <= w_rd1;
      r_rd2  <= w_rd2;
      r_imm  <= w_immext;
      r_pc   <= pc_d;
      r_pc4  <= pcplus4_d;
      r_rs1  <= w_rs1;
      r_rs2  <= w_rs2;
      r_rd   <= w_rd;
    end
  end

  assign stall_req_o  = w_stall_req;
  assign valid_e      = r_ctrl.valid;
  assign regwrite_e   = r_ctrl.regwrite;
  assign resultsrc_e  = r_ctrl.resultsrc;
  assign memwrite_e   = r_ctrl.memwrite;
  assign branch_e     = r_ctrl.branch;
  assign jump_e       = r_ctrl.jump;
  assign alusrc_e     = r_ctrl.alusrc;
  assign alucontrol_e = r_ctrl.alucontrol[ALUC_W-1:0];
  assign rd1_e        = r_rd1;
  assign rd2_e        = r_rd2;
  assign immext_e     = r_imm;
  assign pc_e         = r_pc;
  assign pcplus4_e    = r_pc4;
  assign rs1_e        = r_rs1;
  assign rs2_e        = r_rs2;
  assign rd_e         = r_rd;

  assign w_unused = ^{instr_d, r_ctrl.alucontrol};

endmodule

// File: tb/tb_id_ex_stage_p.sv
// Bench for id_ex_stage_p: directed cases plus random
// traffic against a behavioural decode/ID-EX model.
module tb_id_ex_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        regwrite_d;
  logic [1:0]  resultsrc_d;
  logic        memwrite_d;
  logic        branch_d;
  logic        jump_d;
  logic        alusrc_d;
  logic [2:0]  alucontrol_d;
  logic [2:0]  immsrc_d;
  logic        stall_i;
  logic        flush_i;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        stall_req_o;
  logic        valid_e;
  logic        regwrite_e;
  logic        memwrite_e;
  logic        branch_e;
  logic        jump_e;
  logic        alusrc_e;
  logic [1:0]  resultsrc_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e;
  logic [31:0] rd2_e;
  logic [31:0] immext_e;
  logic [31:0] pc_e;
  logic [31:0] pcplus4_e;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;

  always #5 clk = ~clk;

  id_ex_stage_p dut (
    .clk          (clk),
    .rst          (rst),
    .valid_d      (valid_d),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pcplus4_d    (pcplus4_d),
    .regwrite_d   (regwrite_d),
    .resultsrc_d  (resultsrc_d),
    .memwrite_d   (memwrite_d),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .alusrc_d     (alusrc_d),
    .alucontrol_d (alucontrol_d),
    .immsrc_d     (immsrc_d),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .regwrite_w   (regwrite_w),
    .rd_w         (rd_w),
    .result_w     (result_w),
    .stall_req_o  (stall_req_o),
    .valid_e      (valid_e),
    .regwrite_e   (regwrite_e),
    .memwrite_e   (memwrite_e),
    .branch_e     (branch_e),
    .jump_e       (jump_e),
    .alusrc_e     (alusrc_e),
    .resultsrc_e  (resultsrc_e),
    .alucontrol_e (alucontrol_e),
    .rd1_e        (rd1_e),
    .rd2_e        (rd2_e),
    .immext_e     (immext_e),
    .pc_e         (pc_e),
    .pcplus4_e    (pcplus4_e),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        br;
    logic        jp;
    logic        as;
    logic [2:0]  al;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
  } ex_t;

  ex_t         m;
  ex_t         nx;
  ex_t         zero_ex;
  logic [31:0] rf_m [32];
  logic        last_req;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  // Sign-extend an n-bit field value using arithmetic.
  function automatic logic [31:0] sx(input longint v,
                                     input int bits);
    longint r;
    r = v;
    if (r >= (64'sd1 <<< (bits - 1))) r = r - (64'sd1 <<< bits);
    return r[31:0];
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] i,
                                         input logic [2:0] s);
    longint v;
    case (s)
      3'd0: return sx(longint'(i[31:20]), 12);
      3'd1: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        return sx(v, 12);
      end
      3'd2: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        return sx(v, 13);
      end
      3'd3: begin
        v = longint'(i[31]) * 1048576
          + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048
          + longint'(i[30:21]) * 2;
        return sx(v, 21);
      end
      3'd4: begin
        v = longint'(i[31:12]) * 4096;
        return v[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (regwrite_w && rd_w == a) return result_w;
    return rf_m[a];
  endfunction

  function automatic logic exp_req();
    return m.v && (m.rs == 2'b01) && (m.ad != 5'd0) && valid_d
        && (m.ad == instr_d[19:15] || m.ad == instr_d[24:20]);
  endfunction

  task automatic check_out();
    chk("valid_e", valid_e, m.v);
    chk("regwrite_e", regwrite_e, m.rw);
    chk("resultsrc_e", resultsrc_e, m.rs);
    chk("memwrite_e", memwrite_e, m.mw);
    chk("branch_e", branch_e, m.br);
    chk("jump_e", jump_e, m.jp);
    chk("alusrc_e", alusrc_e, m.as);
    chk("alucontrol_e", alucontrol_e, m.al);
    chk("rd1_e", rd1_e, m.rd1);
    chk("rd2_e", rd2_e, m.rd2);
    chk("immext_e", immext_e, m.imm);
    chk("pc_e", pc_e, m.pc);
    chk("pcplus4_e", pcplus4_e, m.pc4);
    chk("rs1_e", rs1_e, m.a1);
    chk("rs2_e", rs2_e, m.a2);
    chk("rd_e", rd_e, m.ad);
  endtask

  task automatic model_reset();
    m = zero_ex;
    for (int k = 0; k < 32; k++) rf_m[k] = 32'd0;
  endtask

  // One clock: inputs already set after the negedge.
  task automatic cycle();
    logic req;
    #1;
    req      = exp_req();
    last_req = stall_req_o;
    chk("stall_req", stall_req_o, req);
    if (flush_i) nx = zero_ex;
    else if (stall_i) nx = m;
    else if (req) nx = zero_ex;
    else begin
      nx     = zero_ex;
      nx.v   = valid_d;
      if (valid_d) begin
        nx.rw = regwrite_d;
        nx.rs = resultsrc_d;
        nx.mw = memwrite_d;
        nx.br = branch_d;
        nx.jp = jump_d;
        nx.as = alusrc_d;
        nx.al = alucontrol_d;
      end
      nx.rd1 = rd_m(instr_d[19:15]);
      nx.rd2 = rd_m(instr_d[24:20]);
      nx.imm = imm_of(instr_d, immsrc_d);
      nx.pc  = pc_d;
      nx.pc4 = pcplus4_d;
      nx.a1  = instr_d[19:15];
      nx.a2  = instr_d[24:20];
      nx.ad  = instr_d[11:7];
    end
    @(posedge clk);
    if (regwrite_w && rd_w != 5'd0) rf_m[rd_w] = result_w;
    m = nx;
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic set_d(input logic v, input logic [31:0] ins,
                       input logic [1:0] rsrc, input logic rw,
                       input logic [2:0] isrc);
    valid_d      = v;
    instr_d      = ins;
    resultsrc_d  = rsrc;
    regwrite_d   = rw;
    immsrc_d     = isrc;
    memwrite_d   = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alusrc_d     = 1'b1;
    alucontrol_d = 3'd0;
    pc_d         = $urandom & 32'hFFFF_FFFC;
    pcplus4_d    = pc_d + 32'd4;
    regwrite_w   = 1'b0;
    rd_w         = 5'd0;
    result_w     = 32'd0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
  endtask

  initial begin
    zero_ex  = '{default: '0};
    last_req = 1'b0;
    rst      = 1'b0;
    set_d(1'b0, 32'd0, 2'b00, 1'b0, 3'd0);
    model_reset();
    #12;
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // Write-back bypass into the same-cycle decode read.
    set_d(1'b1, 32'h0002_8333, 2'b00, 1'b1, 3'd0);
    regwrite_w = 1'b1;
    rd_w       = 5'd5;
    result_w   = 32'hDEAD_BEEF;
    cycle();
    chk("byp_rd1", rd1_e, 32'hDEAD_BEEF);
    chk("byp_rd2", rd2_e, 32'd0);

    set_d(1'b1, 32'h0000_0333, 2'b00, 1'b1, 3'd0);
    regwrite_w = 1'b1;
    rd_w       = 5'd0;
    result_w   = 32'hFFFF_FFFF;
    cycle();
    chk("x0_rd1", rd1_e, 32'd0);

    set_d(1'b1, 32'h0002_8333, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("x5_kept", rd1_e, 32'hDEAD_BEEF);

    // Immediate formats.
    set_d(1'b1, 32'hFFF0_0093, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("imm_i", immext_e, 32'hFFFF_FFFF);
    set_d(1'b1, 32'hFE00_0EE3, 2'b00, 1'b0, 3'd2);
    cycle();
    chk("imm_b", immext_e, 32'hFFFF_FFFC);
    set_d(1'b1, 32'h1234_50B7, 2'b00, 1'b1, 3'd4);
    cycle();
    chk("imm_u", immext_e, 32'h1234_5000);

    // Load-use hazard, then the rd=x0 exemption.
    set_d(1'b1, 32'h0000_A383, 2'b01, 1'b1, 3'd0);
    cycle();
    set_d(1'b1, 32'h0023_8433, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("lu_req", last_req, 1'b1);
    chk("lu_valid", valid_e, 1'b0);
    chk("lu_rw", regwrite_e, 1'b0);
    set_d(1'b1, 32'h0000_A003, 2'b01, 1'b1, 3'd0);
    cycle();
    set_d(1'b1, 32'h0020_0433, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("lu_x0_req", last_req, 1'b0);
    chk("lu_x0_valid", valid_e, 1'b1);

    // Hold for three cycles.
    set_d(1'b1, 32'h00A0_0513, 2'b00, 1'b1, 3'd0);
    pc_d      = 32'd100;
    pcplus4_d = 32'd104;
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_d(1'b1, $urandom, 2'b00, 1'b1, 3'd1);
      stall_i = 1'b1;
      cycle();
      chk("hold_pc", pc_e, 32'd100);
      chk("hold_imm", immext_e, 32'd10);
    end

    // Flush beats hold.
    stall_i = 1'b1;
    flush_i = 1'b1;
    cycle();
    chk("flush_hold", valid_e, 1'b0);

    // Hold beats a load-use bubble.
    set_d(1'b1, 32'h0000_A383, 2'b01, 1'b1, 3'd0);
    cycle();
    set_d(1'b1, 32'h0023_8433, 2'b00, 1'b1, 3'd0);
    stall_i = 1'b1;
    cycle();
    chk("hz_hold_req", last_req, 1'b1);
    chk("hz_hold_valid", valid_e, 1'b1);
    chk("hz_hold_rs", resultsrc_e, 2'b01);
    chk("hz_hold_rd", rd_e, 5'd7);
    stall_i = 1'b0;
    cycle();
    chk("hz_bubble", valid_e, 1'b0);

    // Invalid slot drops its controls.
    set_d(1'b0, 32'h0000_0093, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("inv_valid", valid_e, 1'b0);
    chk("inv_rw", regwrite_e, 1'b0);

    // Random traffic with dense register overlap.
    for (int n = 0; n < 400; n++) begin
      valid_d       = ($urandom_range(0, 9) != 0);
      instr_d       = $urandom;
      instr_d[19:15] = 5'($urandom_range(0, 7));
      instr_d[24:20] = 5'($urandom_range(0, 7));
      instr_d[11:7]  = 5'($urandom_range(0, 7));
      pc_d          = $urandom & 32'hFFFF_FFFC;
      pcplus4_d     = pc_d + 32'd4;
      regwrite_d    = 1'($urandom);
      resultsrc_d   = 2'($urandom);
      memwrite_d    = 1'($urandom);
      branch_d      = 1'($urandom);
      jump_d        = 1'($urandom);
      alusrc_d      = 1'($urandom);
      alucontrol_d  = 3'($urandom);
      immsrc_d      = 3'($urandom);
      stall_i       = ($urandom_range(0, 9) < 2);
      flush_i       = ($urandom_range(0, 9) == 0);
      regwrite_w    = 1'($urandom);
      rd_w          = 5'($urandom_range(0, 7));
      result_w      = $urandom;
      cycle();
    end

    // Asynchronous reset mid-run.
    set_d(1'b1, 32'h0000_0093, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("pre_rst_valid", valid_e, 1'b1);
    rst = 1'b0;
    #2;
    chk("rst_valid", valid_e, 1'b0);
    chk("rst_rw", regwrite_e, 1'b0);
    chk("rst_pc", pc_e, 32'd0);
    chk("rst_rd", rd_e, 5'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_d(1'b1, 32'h0002_8333, 2'b00, 1'b1, 3'd0);
    cycle();
    chk("rst_x5", rd1_e, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
